// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, gate FSM states and digit increment helper
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  typedef enum logic {IDLE, COUNT} gate_state_t;
  localparam bcd_digit_t BCD_NINE = 4'd9;
  function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
    return (d == BCD_NINE) ? 4'd0 : d + 4'd1;
  endfunction
endpackage

// File: rtl/bcd_digit_clr.sv
// bcd_digit_clr: one decimal digit with sync clear, count enable, saturate hold and carry out
module bcd_digit_clr
  import bcd_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       clr_in,
  input  logic       en_in,
  input  logic       hold_in,
  output bcd_digit_t next_o,
  output logic       carry_o
);
  bcd_digit_t digit_q;
  // next_o ignores clr_in so the top can latch the final value of a window
  assign next_o  = (en_in && !hold_in) ? bcd_inc(digit_q) : digit_q;
  assign carry_o = en_in && digit_q == BCD_NINE;
  always_ff @(posedge clk_in) begin
    if (reset_in || clr_in) digit_q <= '0;
    else digit_q <= next_o;
  end
endmodule

// File: rtl/bcd_gate_counter.sv
// bcd_gate_counter: gated BCD event counter with latched result, blanking mask and strobe
module bcd_gate_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS_NUM  = 6,
  parameter int GATE_CYCLES = 1000000,
  parameter bit SATURATE    = 1'b1
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    run_in,
  input  logic                    event_in,
  output logic [4*DIGITS_NUM-1:0] digits_out,
  output logic [DIGITS_NUM-1:0]   blank_out,
  output logic                    overflow_out,
  output logic                    valid_out
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);
  localparam logic [DIGITS_NUM-1:0] RST_BLANK = ~DIGITS_NUM'(1);
  gate_state_t state_q;
  logic [GW-1:0] gate_q;
  logic win_ovf_q, ovf_q, valid_q;
  logic [4*DIGITS_NUM-1:0] acc_d, digits_q;
  logic [DIGITS_NUM-1:0] blank_q, blank_d;
  logic [DIGITS_NUM:0] carry;
  logic counting, last, clr, hold, z;
  assign counting = state_q == COUNT;
  assign last     = counting && gate_q == LAST;
  assign clr      = !counting || !run_in || last;
  assign carry[0] = counting && event_in;
  // carry out of the top digit is exactly an increment on all-9s
  assign hold     = SATURATE && carry[DIGITS_NUM];
  for (genvar i = 0; i < DIGITS_NUM; i++) begin : g_digit
    bcd_digit_clr u_digit (
      .clk_in  (clk_in),
      .reset_in(reset_in),
      .clr_in  (clr),
      .en_in   (carry[i]),
      .hold_in (hold),
      .next_o  (acc_d[4*i +: 4]),
      .carry_o (carry[i+1])
    );
  end
  always_comb begin
    blank_d = '0;
    z = 1'b1;
    for (int i = DIGITS_NUM - 1; i >= 1; i--) begin
      z = z && acc_d[4*i +: 4] == 4'd0;
      blank_d[i] = z;
    end
  end
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      gate_q    <= '0;
      win_ovf_q <= 1'b0;
      digits_q  <= '0;
      blank_q   <= RST_BLANK;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= run_in ? COUNT : IDLE;
      gate_q    <= clr ? '0 : gate_q + GW'(1);
      win_ovf_q <= clr ? 1'b0 : win_ovf_q || carry[DIGITS_NUM];
      valid_q   <= last;
      if (last) begin
        digits_q <= acc_d;
        blank_q  <= blank_d;
        ovf_q    <= win_ovf_q || carry[DIGITS_NUM];
      end
    end
  end
  assign digits_out   = digits_q;
  assign blank_out    = blank_q;
  assign overflow_out = ovf_q;
  assign valid_out    = valid_q;
endmodule

// File: tb/tb_bcd_gate_counter.sv
// tb_bcd_gate_counter: directed stimulus with a queued scoreboard checked by a strobe monitor
module tb_bcd_gate_counter;
  typedef struct {
    int         cyc;
    logic [15:0] dig;
    logic [3:0]  blk;
    logic        ovf;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run_a = 1'b0, ev_a = 1'b0, run_bc = 1'b0, ev_bc = 1'b0;
  logic [15:0] digits_a;
  logic [3:0]  blank_a;
  logic [7:0]  digits_b, digits_c;
  logic [1:0]  blank_b, blank_c;
  logic ovf_a, ovf_b, ovf_c, valid_a, valid_b, valid_c;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int p, r, q;
  exp_t qa[$], qb[$], qc[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  bcd_gate_counter #(.DIGITS_NUM(4), .GATE_CYCLES(16), .SATURATE(1'b1)) u_a (
    .clk_in(clk), .reset_in(rst), .run_in(run_a), .event_in(ev_a),
    .digits_out(digits_a), .blank_out(blank_a), .overflow_out(ovf_a), .valid_out(valid_a));
  bcd_gate_counter #(.DIGITS_NUM(2), .GATE_CYCLES(128), .SATURATE(1'b1)) u_b (
    .clk_in(clk), .reset_in(rst), .run_in(run_bc), .event_in(ev_bc),
    .digits_out(digits_b), .blank_out(blank_b), .overflow_out(ovf_b), .valid_out(valid_b));
  bcd_gate_counter #(.DIGITS_NUM(2), .GATE_CYCLES(128), .SATURATE(1'b0)) u_c (
    .clk_in(clk), .reset_in(rst), .run_in(run_bc), .event_in(ev_bc),
    .digits_out(digits_c), .blank_out(blank_c), .overflow_out(ovf_c), .valid_out(valid_c));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive_a(input logic rn, input logic ev, input int n);
    run_a = rn;
    ev_a = ev;
    repeat (n) tick();
  endtask
  task automatic drive_bc(input logic rn, input logic ev, input int n);
    run_bc = rn;
    ev_bc = ev;
    repeat (n) tick();
  endtask
  function automatic exp_t mk(input int c, input logic [15:0] d, input logic [3:0] b, input logic o);
    exp_t e;
    e.cyc = c;
    e.dig = d;
    e.blk = b;
    e.ovf = o;
    return e;
  endfunction
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic sb(input string n, input int sz, input exp_t e, input logic [15:0] d,
                    input logic [3:0] b, input logic o);
    checks++;
    if (sz == 0) begin
      failures++;
      $display("FAIL %s: unexpected strobe at cycle %0d dig=%h", n, cyc, d);
    end else if (e.cyc != cyc || e.dig !== d || e.blk !== b || e.ovf !== o) begin
      failures++;
      $display("FAIL %s: got cyc=%0d dig=%h blk=%b ovf=%b expected cyc=%0d dig=%h blk=%b ovf=%b",
               n, cyc, d, b, o, e.cyc, e.dig, e.blk, e.ovf);
    end
  endtask
  initial begin
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        e = mk(0, 16'h0, 4'h0, 1'b0);
        if (valid_a) begin
          if (qa.size() > 0) e = qa[0];
          sb("win_a", qa.size(), e, digits_a, blank_a, ovf_a);
          if (qa.size() > 0) void'(qa.pop_front());
        end
        if (valid_b) begin
          if (qb.size() > 0) e = qb[0];
          sb("win_b_sat", qb.size(), e, {8'h0, digits_b}, {2'b0, blank_b}, ovf_b);
          if (qb.size() > 0) void'(qb.pop_front());
        end
        if (valid_c) begin
          if (qc.size() > 0) e = qc[0];
          sb("win_c_wrap", qc.size(), e, {8'h0, digits_c}, {2'b0, blank_c}, ovf_c);
          if (qc.size() > 0) void'(qc.pop_front());
        end
      end
    join_none
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_digits_a", digits_a, 16'h0000);
    chk("rst_blank_a", {12'h0, blank_a}, 16'h000e);
    chk("rst_ovf_valid_a", {14'h0, ovf_a, valid_a}, 16'h0000);
    chk("rst_blank_b", {14'h0, blank_b}, 16'h0002);
    chk("rst_digits_c", {8'h0, digits_c}, 16'h0000);
    p = cyc;
    qa.push_back(mk(p + 17, 16'h0016, 4'b1100, 1'b0));
    qa.push_back(mk(p + 33, 16'h0016, 4'b1100, 1'b0));
    drive_a(1, 1, 33);
    qa.push_back(mk(p + 49, 16'h0008, 4'b1110, 1'b0));
    repeat (8) begin
      drive_a(1, 1, 1);
      drive_a(1, 0, 1);
    end
    qa.push_back(mk(p + 65, 16'h0000, 4'b1110, 1'b0));
    drive_a(1, 0, 16);
    qa.push_back(mk(p + 81, 16'h0001, 4'b1110, 1'b0));
    drive_a(1, 0, 15);
    drive_a(1, 1, 1);
    qa.push_back(mk(p + 97, 16'h0001, 4'b1110, 1'b0));
    drive_a(1, 1, 1);
    drive_a(1, 0, 15);
    drive_a(1, 1, 5);
    drive_a(0, 1, 3);
    chk("abort_hold_digits", digits_a, 16'h0001);
    chk("abort_hold_blank", {12'h0, blank_a}, 16'h000e);
    r = cyc;
    qa.push_back(mk(r + 17, 16'h0003, 4'b1110, 1'b0));
    drive_a(1, 0, 4);
    drive_a(1, 1, 3);
    drive_a(1, 0, 13);
    rst = 1'b1;
    drive_a(1, 1, 1);
    rst = 1'b0;
    chk("midrst_digits_a", digits_a, 16'h0000);
    chk("midrst_blank_a", {12'h0, blank_a}, 16'h000e);
    chk("midrst_ovf_valid_a", {14'h0, ovf_a, valid_a}, 16'h0000);
    qa.push_back(mk(r + 38, 16'h0016, 4'b1100, 1'b0));
    drive_a(1, 1, 17);
    drive_a(0, 0, 3);
    q = cyc;
    qb.push_back(mk(q + 129, 16'h0099, 4'b0000, 1'b1));
    qc.push_back(mk(q + 129, 16'h0028, 4'b0000, 1'b1));
    qb.push_back(mk(q + 257, 16'h0005, 4'b0010, 1'b0));
    qc.push_back(mk(q + 257, 16'h0005, 4'b0010, 1'b0));
    drive_bc(1, 1, 129);
    drive_bc(1, 1, 5);
    drive_bc(1, 0, 123);
    drive_bc(0, 0, 4);
    chk("missing_strobes_a", 16'(qa.size()), 16'h0);
    chk("missing_strobes_b", 16'(qb.size()), 16'h0);
    chk("missing_strobes_c", 16'(qc.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_gate_counter.md
# bcd_gate_counter

Parametrised, self-timed BCD event counter for the frequency-counter datapath. It counts single-cycle `event_in` pulses over a fixed gate window of `GATE_CYCLES` clocks and latches the result into a held BCD register. It also produces a leading-zero blanking mask, a per-window overflow flag and a one-cycle `valid_out` strobe for the OLED formatting stage. It supersedes the free-running cascaded BCD counter: it adds gate timing, result latching, run/abort control and overflow handling (saturate or wrap).

## Interface
- `DIGITS_NUM`, 6, number of BCD digits (≥1).
- `GATE_CYCLES`, 1000000, gate window length in `clk_in` cycles (≥2).
- `SATURATE`, 1, 1 = stop at all-9s on overflow; 0 = wrap to 0.
- `clk_in`, input, 1, the single clock; all logic on its rising edge.
- `reset_in`, input, 1, synchronous, active-high reset.
- `run_in`, input, 1, level; 1 = measure continuously, 0 = idle/abort.
- `event_in`, input, 1, one-cycle event pulse, already synchronous to `clk_in`.
- `digits_out`, output, 4*DIGITS_NUM, latched result, digit 0 in [3:0].
- `blank_out`, output, DIGITS_NUM, bit i = 1 when digit i is a leading zero.
- `overflow_out`, output, 1, latched: window exceeded 10^DIGITS_NUM−1 events.
- `valid_out`, output, 1, one-cycle strobe when a new result is latched.

## Operation
- FSM states: IDLE and COUNT.
  - IDLE: gate counter = 0, accumulator = 0, overflow flag = 0. Go to COUNT when `run_in`=1.
  - COUNT: gate counter increments every cycle from 0 to GATE_CYCLES−1. `event_in` increments the BCD accumulator.
  - `run_in`=0 in COUNT returns the FSM to IDLE next cycle. The partial window is discarded, no `valid_out` is issued, and the outputs hold the previous result.
- Accumulator: DIGITS_NUM cascaded decimal digits, 9→0 with carry into the next digit.
- Increment with all digits = 9:
  - The window overflow flag is set.
  - SATURATE=1: the accumulator holds all-9s.
  - SATURATE=0: the accumulator wraps to all-0s.
  - The flag stays set until the end of the window.
- Window end is the cycle in COUNT where gate counter = GATE_CYCLES−1:
  - The latch captures the accumulator plus that cycle's `event_in`, and the overflow flag including any overflow on that cycle.
  - Accumulator, flag and gate counter clear to 0.
  - If `run_in` is still 1, the FSM stays in COUNT and the next window starts on the following cycle with no dead cycle.
  - An event on the first cycle of the next window counts in the next window.
- `blank_out[i]` = 1 iff digits i..DIGITS_NUM−1 of the latched result are all 0, for i ≥ 1. `blank_out[0]` is always 0. The mask is computed from the latched value and registered alongside it.
- `reset_in` overrides everything, including mid-window. The FSM goes to IDLE and the partial window is lost.

## Timing
- Reset values:
  - `digits_out` = 0.
  - `blank_out` = all ones except bit 0.
  - `overflow_out` = 0, `valid_out` = 0.
  - FSM = IDLE, gate counter = 0, accumulator = 0.
- `run_in` rising while in IDLE: COUNT is entered on the next edge, and that cycle is gate count 0.
- Window length: exactly GATE_CYCLES cycles of event sampling.
- `digits_out`, `blank_out` and `overflow_out` update on the edge that ends the window's last cycle. `valid_out` is high during the cycle that immediately follows, coincident with the new values.
- `valid_out` pulses are therefore GATE_CYCLES cycles apart during continuous run.
- Outputs are stable between strobes.
- Event-to-accumulator latency: 1 cycle.
- Gate counter width: `$clog2(GATE_CYCLES)`.
- Carry ripple across digits is combinational within one cycle. The designer must ensure DIGITS_NUM ≤ 8 meets timing at the system clock.

## Structure
- Package `bcd_pkg`:
  - `bcd_digit_t` (4-bit).
  - FSM state enum `gate_state_t` {IDLE, COUNT}.
  - Constant `BCD_NINE` = 4'd9.
- Sub-module `bcd_digit_clr`: one decimal digit with synchronous reset, synchronous clear, count enable, saturate-hold input and carry out. It is instantiated DIGITS_NUM times via generate.
- Top level owns the gate counter, FSM, overflow flag, result latch, blanking mask and strobe.

## Test plan
- DIGITS_NUM=4, GATE_CYCLES=16, `run_in`=1, `event_in` held 1 → first `valid_out` 16 cycles after COUNT entry with `digits_out`=16'h0016, `blank_out`=4'b1100, `overflow_out`=0. Repeats every 16 cycles.
- Same configuration, event on alternate cycles → 16'h0008, `blank_out`=4'b1110. No events → 16'h0000, `blank_out`=4'b1110.
- DIGITS_NUM=2, GATE_CYCLES=128, event every cycle:
  - SATURATE=1 → `digits_out`=8'h99, `overflow_out`=1.
  - SATURATE=0 → 8'h28, `overflow_out`=1.
  - Next window with 5 events → 8'h05, `overflow_out`=0.
- Single event on the last gate cycle → that window reads 1. Single event on the first cycle of the following window → the next window reads 1 and the first window is unaffected.
- `run_in` dropped at gate count 5 → no `valid_out` and previous result held. Re-raised → a full 16-cycle window, then a correct result.
- `reset_in` pulsed mid-window → all outputs return to reset values next cycle and no stale strobe appears. With `run_in`=1, measurement restarts from gate count 0.
